// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the miniuart receive buffer: status-word bit positions
// (the same values the miniuart and firmware headers use) and the status packer.
package uart_rx_fifo_pkg;

  localparam int UART_ST_TXBUSY  = 0;
  localparam int UART_ST_RXAVAIL = 1;
  localparam int UART_ST_OVR     = 2;
  localparam int UART_ST_FULL    = 3;
  localparam int UART_ST_CNT_LSB = 8;
  localparam int UART_ST_CNT_W   = 8;

  typedef struct packed {
    logic       tx_busy;
    logic       nonempty;
    logic       overrun;
    logic       full;
    logic [7:0] count;
  } rx_status_t;

  // Any bit without an assigned meaning reads as zero.
  function automatic logic [31:0] pack_status(input rx_status_t st);
    logic [31:0] word;
    word                                  = '0;
    word[UART_ST_TXBUSY]                  = st.tx_busy;
    word[UART_ST_RXAVAIL]                 = st.nonempty;
    word[UART_ST_OVR]                     = st.overrun;
    word[UART_ST_FULL]                    = st.full;
    word[UART_ST_CNT_LSB +: UART_ST_CNT_W] = st.count;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Byte FIFO with a first-word-fall-through output. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; a pop of an empty FIFO is ignored.
module sync_fifo_core #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// miniuart receive buffer: captures received-byte strobes into a FIFO and maps it
// onto the CPU data/status registers, with sticky overrun and a level interrupt.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  input  logic        reg_state_re,
  output logic [31:0] reg_state_do,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] THR = (AW+1)'(THRESHOLD);

  logic [7:0]  head;
  logic [AW:0] count;
  logic [AW:0] count_next;
  logic        full;
  logic        empty;
  logic        overrun;
  logic        overrun_next;
  logic        irq_next;
  rx_status_t  status;

  sync_fifo_core #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rx_valid),
    .pop        (reg_dat_re),
    .din        (rx_data),
    .dout       (head),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // A byte is lost only when full with no pop freeing a slot; a coincident clear loses to the set.
  assign overrun_next = (rx_valid && full && !reg_dat_re) || (overrun && !reg_state_re);
  assign irq_next     = (count_next >= THR) || overrun_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      overrun <= overrun_next;
      irq     <= irq_next;
    end
  end

  always_comb begin
    status          = '0;
    status.tx_busy  = tx_busy;
    status.nonempty = !empty;
    status.overrun  = overrun;
    status.full     = full;
    status.count    = 8'(count);
  end

  assign reg_dat_do   = empty ? 32'h0 : {24'h0, head};
  assign reg_state_do = pack_status(status);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model; two instances cover THRESHOLD=1 and THRESHOLD=4.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic        reg_state_re = 1'b0;
  logic [31:0] dat_a, st_a, dat_b, st_b;
  logic        irq_a, irq_b;
  logic [31:0] seen;

  int checks = 0;
  int failures = 0;

  byte unsigned q[$];
  bit           m_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(1)) u_dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .reg_dat_re(reg_dat_re), .reg_dat_do(dat_a), .reg_state_re(reg_state_re),
    .reg_state_do(st_a), .irq(irq_a)
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(4)) u_dut4 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .reg_dat_re(reg_dat_re), .reg_dat_do(dat_b), .reg_state_re(reg_state_re),
    .reg_state_do(st_b), .irq(irq_b)
  );

  function automatic logic [31:0] exp_dat();
    return (q.size() == 0) ? 32'h0 : {24'h0, q[0]};
  endfunction

  function automatic logic [31:0] exp_st();
    return {16'h0, 8'(q.size()), 4'h0, (q.size() == DEPTH), m_ovr, (q.size() != 0), tx_busy};
  endfunction

  function automatic logic exp_irq(input int th);
    return (q.size() >= th) || m_ovr;
  endfunction

  // Drives one clock cycle of stimulus, samples reg_dat_do before the edge, updates the model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit re, input bit sre,
                       output logic [31:0] head_seen);
    bit pop_ok, push_ok, set_ovr;
    rx_valid = v; rx_data = d; reg_dat_re = re; reg_state_re = sre;
    #1 head_seen = dat_a;
    @(posedge clk);
    pop_ok  = re && (q.size() > 0);
    push_ok = v && ((q.size() < DEPTH) || pop_ok);
    set_ovr = v && (q.size() == DEPTH) && !re;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    if (set_ovr) m_ovr = 1'b1;
    else if (sre) m_ovr = 1'b0;
    #1 rx_valid = 1'b0; reg_dat_re = 1'b0; reg_state_re = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    checks++; if (st_a !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", st_a, 32'h0); end
    checks++; if (dat_a !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", dat_a, 32'h0); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b%b exp=00", irq_a, irq_b); end
    tx_busy = 1'b1; #1;
    checks++; if (st_a !== 32'h1) begin failures++; $display("FAIL reset_txbusy got=%h exp=%h", st_a, 32'h1); end
    tx_busy = 1'b0;
  endtask

  task automatic test_order();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, seen);
    checks++; if (st_a !== 32'h0000_0302) begin failures++; $display("FAIL order_status got=%h exp=%h", st_a, 32'h302); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL order_irq_high pop=%0d got=%b exp=1", i, irq_a); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, seen);
      checks++; if (seen !== 32'(8'h41 + i)) begin failures++; $display("FAIL order_data pop=%0d got=%h exp=%h", i, seen, 32'(8'h41 + i)); end
    end
    checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL order_irq_low got=%b exp=0", irq_a); end
    checks++; if (st_a !== 32'h0) begin failures++; $display("FAIL order_empty got=%h exp=%h", st_a, 32'h0); end
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, seen);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, seen);
    checks++; if (st_a !== 32'h0000_100E) begin failures++; $display("FAIL full_ovr_status got=%h exp=%h", st_a, 32'h100E); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, seen);
    checks++; if (st_a !== 32'h0000_100A) begin failures++; $display("FAIL ovr_clear got=%h exp=%h", st_a, 32'h100A); end
    cycle(1'b1, 8'h55, 1'b1, 1'b0, seen);
    checks++; if (seen !== 32'h00) begin failures++; $display("FAIL full_pushpop_data got=%h exp=%h", seen, 32'h0); end
    checks++; if (st_a !== 32'h0000_100A) begin failures++; $display("FAIL full_pushpop_status got=%h exp=%h", st_a, 32'h100A); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, seen);
      checks++;
      if (seen !== ((i < DEPTH - 1) ? 32'(i + 1) : 32'h55)) begin
        failures++; $display("FAIL full_drain idx=%0d got=%h exp=%h", i, seen, (i < DEPTH - 1) ? 32'(i + 1) : 32'h55);
      end
    end
    checks++; if (st_a !== 32'h0) begin failures++; $display("FAIL full_drained got=%h exp=%h", st_a, 32'h0); end
  endtask

  task automatic test_ovr_set_wins();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, seen);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, seen);
    checks++; if (st_a[2] !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", st_a[2]); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, seen);
    checks++; if (st_a[2] !== 1'b0) begin failures++; $display("FAIL ovr_isolated_clear got=%b exp=0", st_a[2]); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, seen);
    checks++; if (st_a !== 32'h0) begin failures++; $display("FAIL ovr_drained got=%h exp=%h", st_a, 32'h0); end
  endtask

  task automatic test_empty_push_pop();
    cycle(1'b1, 8'h7E, 1'b1, 1'b0, seen);
    checks++; if (seen !== 32'h0) begin failures++; $display("FAIL empty_pop_data got=%h exp=%h", seen, 32'h0); end
    checks++; if (st_a !== 32'h0000_0102) begin failures++; $display("FAIL empty_pushpop_status got=%h exp=%h", st_a, 32'h102); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, seen);
    checks++; if (seen !== 32'h7E) begin failures++; $display("FAIL empty_pushpop_data got=%h exp=%h", seen, 32'h7E); end
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 8'(k), 1'b0, 1'b0, seen);
      checks++; if (irq_b !== (k >= 4)) begin failures++; $display("FAIL thr4_irq push=%0d got=%b exp=%b", k, irq_b, (k >= 4)); end
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, seen);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, seen);
    checks++; if (st_a[15:8] !== 8'd5) begin failures++; $display("FAIL mid_count got=%h exp=%h", st_a[15:8], 8'd5); end
    rx_valid = 1'b1; rx_data = 8'h99; reg_dat_re = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (st_a !== 32'h0) begin failures++; $display("FAIL mid_reset_status got=%h exp=%h", st_a, 32'h0); end
    checks++; if (dat_a !== 32'h0 || irq_a !== 1'b0) begin failures++; $display("FAIL mid_reset_out got=%h/%b exp=0/0", dat_a, irq_a); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0; reg_dat_re = 1'b0;
    q.delete(); m_ovr = 1'b0;
    #1;
    checks++; if (st_a !== 32'h0 || st_b !== 32'h0) begin failures++; $display("FAIL mid_release got=%h/%h exp=0/0", st_a, st_b); end
  endtask

  task automatic test_random();
    logic [31:0] head_exp;
    int pv, pr;
    for (int n = 0; n < 400; n++) begin
      pv = (n < 200) ? 70 : 30;
      pr = (n < 200) ? 30 : 70;
      tx_busy = 1'($urandom);
      head_exp = exp_dat();
      cycle(($urandom_range(99) < pv), 8'($urandom), ($urandom_range(99) < pr),
            ($urandom_range(99) < 10), seen);
      checks++; if (seen !== head_exp) begin failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, seen, head_exp); end
      checks++; if (st_a !== exp_st() || st_b !== exp_st()) begin failures++; $display("FAIL rand_status n=%0d got=%h/%h exp=%h", n, st_a, st_b, exp_st()); end
      checks++; if (irq_a !== exp_irq(1) || irq_b !== exp_irq(4)) begin failures++; $display("FAIL rand_irq n=%0d got=%b%b exp=%b%b", n, irq_a, irq_b, exp_irq(1), exp_irq(4)); end
    end
    tx_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_overrun();
    test_ovr_set_wins();
    test_empty_push_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
